// File: rtl/rgb_fader.sv
// rgb_fader: ramps each RGB channel toward its target by at most STEP per tick,
// with a bypass mode that passes targets straight through.

module rgb_fader_lane #(
  parameter int LVL_W = 15,
  parameter int STEP  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bypass,
  input  logic             tick,
  input  logic [LVL_W-1:0] tgt_raw,
  input  logic [LVL_W-1:0] tgt_q,
  output logic [LVL_W-1:0] lvl,
  output logic [LVL_W-1:0] nxt
);
  localparam logic [LVL_W:0] STEP_X = (LVL_W+1)'(STEP);

  logic [LVL_W:0] cur_x, tgt_x, up_x;

  assign cur_x = {1'b0, lvl};
  assign tgt_x = {1'b0, tgt_q};
  assign up_x  = cur_x + STEP_X;

  // Both directions clamp at the target, so the extra bit never wraps.
  always_comb begin
    nxt = lvl;
    if (cur_x < tgt_x)
      nxt = (up_x > tgt_x) ? tgt_q : up_x[LVL_W-1:0];
    else if (cur_x > tgt_x)
      nxt = (cur_x < tgt_x + STEP_X) ? tgt_q : lvl - STEP_X[LVL_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lvl <= '0;
    else if (bypass) lvl <= tgt_raw;
    else if (tick)   lvl <= nxt;
  end
endmodule

module rgb_fader #(
  parameter int LVL_W     = 15,
  parameter int STEP      = 64,
  parameter int TICK_BASE = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       rate_sel,
  input  logic [LVL_W-1:0] red_tgt,
  input  logic [LVL_W-1:0] green_tgt,
  input  logic [LVL_W-1:0] blue_tgt,
  output logic [LVL_W-1:0] red,
  output logic [LVL_W-1:0] green,
  output logic [LVL_W-1:0] blue,
  output logic             busy,
  output logic             done
);
  localparam int NUM_LANES = 3;
  localparam int CNT_W     = $clog2(TICK_BASE*8 + 1);

  typedef enum logic [0:0] {IDLE, RAMP} state_t;

  state_t                              state;
  logic [CNT_W-1:0]                    cnt, lim;
  logic                                tick;
  logic [NUM_LANES-1:0][LVL_W-1:0]     tgt_in, tgt_q, lvl, nxt;

  assign tgt_in = {red_tgt, green_tgt, blue_tgt};
  assign {red, green, blue} = lvl;

  // Limit follows the live rate_sel; >= lets a shortened period fire at once.
  assign lim  = CNT_W'((TICK_BASE << rate_sel) - 1);
  assign tick = enable && (state == RAMP) && (cnt >= lim);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rgb_fader_lane #(.LVL_W(LVL_W), .STEP(STEP)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .bypass  (!enable),
      .tick    (tick),
      .tgt_raw (tgt_in[i]),
      .tgt_q   (tgt_q[i]),
      .lvl     (lvl[i]),
      .nxt     (nxt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      tgt_q <= '0;
    end else begin
      tgt_q <= tgt_in;
      done  <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tgt_q != lvl) begin
              state <= RAMP;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          RAMP: begin
            if (tick) begin
              cnt <= '0;
              if (nxt == tgt_q) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rgb_fader.sv
// Scoreboard bench for rgb_fader: stimulus predicts each output change and done
// pulse (with its cycle); a monitor pops and compares whenever outputs move.

module tb_rgb_fader;
  localparam int LVL_W = 15;
  localparam int STEP  = 64;
  localparam int TB    = 8;
  localparam int MAXV  = (1 << LVL_W) - 1;

  logic             clk = 0, rst_n = 1, enable = 1;
  logic [1:0]       rate_sel = 0;
  logic [LVL_W-1:0] red_tgt = 0, green_tgt = 0, blue_tgt = 0;
  logic [LVL_W-1:0] red, green, blue;
  logic             busy, done;

  always #5 clk = ~clk;

  rgb_fader #(.LVL_W(LVL_W), .STEP(STEP), .TICK_BASE(TB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rate_sel(rate_sel),
    .red_tgt(red_tgt), .green_tgt(green_tgt), .blue_tgt(blue_tgt),
    .red(red), .green(green), .blue(blue), .busy(busy), .done(done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int r; int g; int b; bit busy; bit done; } ev_t;
  ev_t q[$];

  int m_cur[3], m_tgt[3];
  int last_tick;
  bit conv;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int period();
    return TB << rate_sel;
  endfunction

  function automatic int stepv(input int c, input int t);
    if (c < t) return (c + STEP > t) ? t : c + STEP;
    if (c > t) return (c - STEP < t) ? t : c - STEP;
    return c;
  endfunction

  // Model a ramp tick by tick from the given first-tick cycle, at most maxt ticks.
  task automatic push_ticks(input int first, input int maxt);
    int t;
    t = first;
    conv = 0;
    for (int n = 0; n < maxt && !conv; n++) begin
      bit ch;
      ch = 0;
      for (int k = 0; k < 3; k++) begin
        int nx;
        nx = stepv(m_cur[k], m_tgt[k]);
        if (nx != m_cur[k]) ch = 1;
        m_cur[k] = nx;
      end
      conv = (m_cur[0] == m_tgt[0]) && (m_cur[1] == m_tgt[1]) && (m_cur[2] == m_tgt[2]);
      if (conv)    q.push_back('{t, m_cur[0], m_cur[1], m_cur[2], 1'b0, 1'b1});
      else if (ch) q.push_back('{t, m_cur[0], m_cur[1], m_cur[2], 1'b1, 1'b0});
      last_tick = t;
      t += period();
    end
  endtask

  task automatic set_tgt(input int r, input int g, input int b);
    red_tgt = LVL_W'(r); green_tgt = LVL_W'(g); blue_tgt = LVL_W'(b);
    m_tgt[0] = r; m_tgt[1] = g; m_tgt[2] = b;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic start_ramp(input int r, input int g, input int b, input int maxt);
    @(posedge clk); #1;
    set_tgt(r, g, b);
    push_ticks(cyc + 2 + period(), maxt);
  endtask

  // New target lands right after a step; it applies from the following tick.
  task automatic retarget(input int r, input int g, input int b, input int maxt);
    int first;
    at_cycle(last_tick);
    set_tgt(r, g, b);
    first = last_tick + period();
    push_ticks(first, maxt);
  endtask

  task automatic bypass_set(input int r, input int g, input int b);
    @(posedge clk); #1;
    enable = 0;
    set_tgt(r, g, b);
    if (r != m_cur[0] || g != m_cur[1] || b != m_cur[2])
      q.push_back('{cyc + 1, r, g, b, 1'b0, 1'b0});
    m_cur[0] = r; m_cur[1] = g; m_cur[2] = b;
    repeat (3) @(posedge clk);
    #1 enable = 1;
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while (q.size() > 0 && k < limit) begin @(posedge clk); k++; end
    if (q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d events still pending, expected 0", q.size());
      q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: any output change or done pulse must match the queue head.
  initial begin
    logic [3*LVL_W-1:0] prev, now;
    prev = '0;
    forever begin
      @(negedge clk);
      now = {red, green, blue};
      if (!rst_n) prev = '0;
      else begin
        if (now != prev || done) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_event: cyc %0d r=%0d g=%0d b=%0d done=%0b, expected none",
                     cyc, red, green, blue, done);
          end else begin
            ev_t e;
            e = q.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("red", int'(red), e.r);
            chk("green", int'(green), e.g);
            chk("blue", int'(blue), e.b);
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
          end
        end
        prev = now;
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin m_cur[k] = 0; m_tgt[k] = 0; end
    #1 rst_n = 0;
    #11;
    chk("rst_red", int'(red), 0);
    chk("rst_green", int'(green), 0);
    chk("rst_blue", int'(blue), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1 rst_n = 1;

    // Ramp up, ramp down to a non-multiple, retarget mid-ramp with reversal.
    start_ramp(200, 0, 0, 1000);   wait_drain(500);
    start_ramp(10, 0, 0, 1000);    wait_drain(500);
    start_ramp(10, 1000, 0, 2);
    retarget(10, 100, 0, 1000);    wait_drain(500);

    // Slow rate and range boundaries.
    rate_sel = 3;
    bypass_set(10, 100, 32740);    wait_drain(20);
    start_ramp(10, 100, MAXV, 1000); wait_drain(500);
    bypass_set(10, 100, 30);       wait_drain(20);
    start_ramp(10, 100, 0, 1000);  wait_drain(500);

    // Abort mid-ramp via bypass, then bypass a full-scale target.
    rate_sel = 0;
    start_ramp(5000, 3000, 200, 3);
    at_cycle(last_tick + 1);
    bypass_set(111, 222, 333);     wait_drain(20);
    bypass_set(111, 222, MAXV);    wait_drain(20);

    // Asynchronous reset between edges mid-ramp, then restart from zero.
    start_ramp(700, 0, 900, 2);
    at_cycle(last_tick + 2);
    wait_drain(10);
    #2 rst_n = 0;
    #1;
    chk("arst_red", int'(red), 0);
    chk("arst_green", int'(green), 0);
    chk("arst_blue", int'(blue), 0);
    chk("arst_busy", int'(busy), 0);
    for (int k = 0; k < 3; k++) m_cur[k] = 0;
    @(posedge clk); #1 rst_n = 1;
    push_ticks(cyc + 2 + period(), 1000);
    wait_drain(3000);

    // Randomized ramps, some retargeted after two ticks.
    for (int it = 0; it < 24; it++) begin
      int nt[3];
      bit same;
      rate_sel = 2'($urandom_range(0, 3));
      same = 1;
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) nt[k] = m_cur[k];
        else nt[k] = m_cur[k] + int'($urandom_range(0, 1000)) - 500;
        if (nt[k] < 0) nt[k] = 0;
        if (nt[k] > MAXV) nt[k] = MAXV;
        if (nt[k] != m_cur[k]) same = 0;
      end
      if (same) continue;
      if ($urandom_range(0, 3) == 0) begin
        start_ramp(nt[0], nt[1], nt[2], 2);
        if (!conv) begin
          for (int k = 0; k < 3; k++) begin
            nt[k] = m_cur[k] + int'($urandom_range(0, 600)) - 300;
            if (nt[k] < 0) nt[k] = 0;
            if (nt[k] > MAXV) nt[k] = MAXV;
          end
          retarget(nt[0], nt[1], nt[2], 1000);
        end
      end else begin
        start_ramp(nt[0], nt[1], nt[2], 1000);
      end
      wait_drain(8000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
